// File: rtl/cpu_bus_slave_pkg.sv
// Shared constants for the 8051 control-bus responder: register map,
// time-preset limits and status bit positions.
package cpu_bus_slave_pkg;

   localparam logic [7:0] ADDR_MASK     = 8'd7;
   localparam logic [7:0] ADDR_HOUR     = 8'd8;
   localparam logic [7:0] ADDR_MINUTE   = 8'd9;
   localparam logic [7:0] ADDR_STATUS   = 8'd10;
   localparam logic [7:0] ADDR_CUR_HOUR = 8'd11;
   localparam logic [7:0] ADDR_CUR_MIN  = 8'd12;

   localparam logic [7:0] HOUR_MAX   = 8'd23;
   localparam logic [7:0] MINUTE_MAX = 8'd59;

   localparam int STAT_ERR_RANGE = 0;
   localparam int STAT_ERR_ADDR  = 1;

   // Range check for the two time-preset registers; addr is assumed to be
   // ADDR_HOUR or ADDR_MINUTE.
   function automatic logic time_ok(input logic [7:0] addr, input logic [7:0] data);
      if (addr == ADDR_HOUR) return data <= HOUR_MAX;
      return data <= MINUTE_MAX;
   endfunction

endpackage

// File: rtl/cpu_bus_slave_sync.sv
// N-stage synchroniser with one extra history flop. Edges are taken from the
// last synchroniser stage against the history flop, so every bus signal run
// through an instance of this block keeps its timing relative to the others.
module bus_sync_edge #(
   parameter int               STAGES  = 2,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] hist_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] hist_q;

   // Shift the pin value through the synchroniser chain and history flop.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
         hist_q <= RST_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
         hist_q <= stage_q[STAGES-1];
      end
   end

   assign q_o    = stage_q[STAGES-1];
   assign hist_o = hist_q;
   assign rise_o = q_o & ~hist_q;
   assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/cpu_bus_slave.sv
// 8051 multiplexed-bus register slave: coefficient, mask and time-preset
// registers with range/address error flags.
// Build option CPU_BUS_RDBK_EN: when defined, CPU reads are served on dbus
// and a status read clears the error flags; when undefined dbus is input-only
// and the error flags stay set until reset.
module cpu_bus_slave
   import cpu_bus_slave_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] PAGE        = 8'h00,
   parameter int         NUM_COEF    = 7
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  cs_n,
   input  logic                  ale,
   input  logic [7:0]            abus,
   input  logic                  r_n,
   input  logic                  w_n,
   inout  wire  [7:0]            dbus,
   input  logic [7:0]            cur_hour,
   input  logic [7:0]            cur_minute,
   output logic [8*NUM_COEF-1:0] coef,
   output logic [7:0]            mask,
   output logic [7:0]            hour_set,
   output logic [7:0]            minute_set,
   output logic                  time_load
);

   // Strobes idle high, so their synchronisers reset to the idle level.
   logic [2:0] ctl_s, ctl_h, ctl_r, ctl_f;
   logic [7:0] abus_s, abus_h, abus_r, abus_f;
   logic [7:0] dbus_s, dbus_h, dbus_r, dbus_f;

   bus_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(3), .RST_VAL(3'b110)) u_sync_ctl (
      .clock(clock), .rst_n(rst_n), .d_i({cs_n, w_n, ale}),
      .q_o(ctl_s), .hist_o(ctl_h), .rise_o(ctl_r), .fall_o(ctl_f));

   bus_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(8), .RST_VAL(8'h00)) u_sync_abus (
      .clock(clock), .rst_n(rst_n), .d_i(abus),
      .q_o(abus_s), .hist_o(abus_h), .rise_o(abus_r), .fall_o(abus_f));

   bus_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(8), .RST_VAL(8'h00)) u_sync_dbus (
      .clock(clock), .rst_n(rst_n), .d_i(dbus),
      .q_o(dbus_s), .hist_o(dbus_h), .rise_o(dbus_r), .fall_o(dbus_f));

   logic cs_s, cs_rise, w_rise, ale_s, ale_fall;
   assign cs_s     = ctl_s[2];
   assign cs_rise  = ctl_r[2];
   assign w_rise   = ctl_r[1];
   assign ale_s    = ctl_s[0];
   assign ale_fall = ctl_f[0];

   logic unused_sync;
   assign unused_sync = ^{ctl_h, ctl_f[2:1], ctl_r[0], abus_s, abus_r, abus_f,
                          dbus_s, dbus_r, dbus_f};

   logic [15:0] addr_q;
   logic        addr_valid_q;
   logic        page_hit;
   assign page_hit = (addr_q[15:8] == PAGE);

   // Latch {abus, dbus} from the history stage on ale fall; drop it at end of select.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
      end else if (cs_rise) begin
         addr_valid_q <= 1'b0;
      end else if (ale_fall && !cs_s) begin
         addr_q       <= {abus_h, dbus_h};
         addr_valid_q <= 1'b1;
      end
   end

   // The history stage still holds the data sampled while w_n was low.
   logic       wr_fire;
   logic       wr_pend_q;
   logic [7:0] wr_addr_q;
   logic [7:0] wr_data_q;
   assign wr_fire = w_rise & ~cs_s & ~ale_s & addr_valid_q & page_hit;

   // Register the decoded write; the commit happens on the following edge.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_pend_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_pend_q <= wr_fire;
         if (wr_fire) begin
            wr_addr_q <= addr_q[7:0];
            wr_data_q <= dbus_h;
         end
      end
   end

   logic       wr_coef, wr_time, wr_time_ok;
   logic [1:0] err_set;
   logic [1:0] err_q;
   logic       stat_clr;

   assign wr_coef    = wr_pend_q & (int'(wr_addr_q) < NUM_COEF);
   assign wr_time    = (wr_addr_q == ADDR_HOUR) | (wr_addr_q == ADDR_MINUTE);
   assign wr_time_ok = time_ok(wr_addr_q, wr_data_q);

   always_comb begin
      err_set                 = '0;
      err_set[STAT_ERR_RANGE] = wr_pend_q & ~wr_coef & wr_time & ~wr_time_ok;
      err_set[STAT_ERR_ADDR]  = wr_pend_q & ~wr_coef & (wr_addr_q >= ADDR_STATUS);
   end

   logic [7:0] coef_q [NUM_COEF];
   logic [7:0] mask_q, hour_q, minute_q;
   logic       time_load_q;

   // Commit accepted writes; time_load marks an accepted time-preset write.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_COEF; i++) coef_q[i] <= '0;
         mask_q      <= '0;
         hour_q      <= '0;
         minute_q    <= '0;
         time_load_q <= 1'b0;
      end else begin
         time_load_q <= 1'b0;
         if (wr_coef) begin
            for (int i = 0; i < NUM_COEF; i++)
               if (wr_addr_q == 8'(i)) coef_q[i] <= wr_data_q;
         end else if (wr_pend_q) begin
            if (wr_addr_q == ADDR_MASK) begin
               mask_q <= wr_data_q;
            end else if (wr_time && wr_time_ok) begin
               if (wr_addr_q == ADDR_HOUR) hour_q   <= wr_data_q;
               else                        minute_q <= wr_data_q;
               time_load_q <= 1'b1;
            end
         end
      end
   end

   // Sticky error flags; a new error outranks a simultaneous clear.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) err_q <= '0;
      else        err_q <= (err_q & ~{2{stat_clr}}) | err_set;
   end

   for (genvar g = 0; g < NUM_COEF; g++) begin : g_coef
      assign coef[8*g +: 8] = coef_q[g];
   end

   assign mask       = mask_q;
   assign hour_set   = hour_q;
   assign minute_set = minute_q;
   assign time_load  = time_load_q;

`ifdef CPU_BUS_RDBK_EN
   logic r_s, r_h, r_rise, r_fall;

   bus_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_rd (
      .clock(clock), .rst_n(rst_n), .d_i(r_n),
      .q_o(r_s), .hist_o(r_h), .rise_o(r_rise), .fall_o(r_fall));

   logic rd_fire;
   logic rd_active_q;
   logic [7:0] rd_data_q;
   logic [7:0] rd_mux;
   assign rd_fire  = r_fall & ~cs_s & addr_valid_q & page_hit;
   assign stat_clr = rd_fire & (addr_q[7:0] == ADDR_STATUS);

   // Read mux; coefficient addresses take precedence, unmapped reads give 0.
   always_comb begin
      rd_mux = '0;
      case (addr_q[7:0])
         ADDR_MASK:     rd_mux = mask_q;
         ADDR_HOUR:     rd_mux = hour_q;
         ADDR_MINUTE:   rd_mux = minute_q;
         ADDR_STATUS:   rd_mux = {6'b0, err_q};
         ADDR_CUR_HOUR: rd_mux = cur_hour;
         ADDR_CUR_MIN:  rd_mux = cur_minute;
         default:       rd_mux = '0;
      endcase
      for (int i = 0; i < NUM_COEF; i++)
         if (addr_q[7:0] == 8'(i)) rd_mux = coef_q[i];
   end

   // Capture read data on strobe fall; hold until the strobe is seen to rise.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_active_q <= 1'b0;
         rd_data_q   <= '0;
      end else if (rd_fire) begin
         rd_active_q <= 1'b1;
         rd_data_q   <= rd_mux;
      end else if (r_rise) begin
         rd_active_q <= 1'b0;
      end
   end

   // Gate on the raw pins so the bus is released the moment the CPU lets go.
   assign dbus = (rd_active_q & ~r_n & ~cs_n) ? rd_data_q : 8'hzz;

   logic unused_rd;
   assign unused_rd = ^{r_s, r_h};
`else
   assign stat_clr = 1'b0;

   logic unused_rd;
   assign unused_rd = ^{r_n, cur_hour, cur_minute, err_q};
`endif

endmodule
